multi_product_vending_ctrl: RTL

//  Next-generation vending controller: N products with per-product price and stock, coin credit

---
 rtl/vend_pkg.sv | 26 ++
 rtl/vend_change_gen.sv | 25 ++
 rtl/multi_product_vending_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared FSM state, coin codes and coin value helper for the vending controller
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1C   = 2'b01;
    localparam logic [1:0] COIN_5C   = 2'b10;
    localparam logic [1:0] COIN_10C  = 2'b11;

    // Face value in cents of a coin code; COIN_NONE is worth nothing.
    function automatic logic [3:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_1C:  return 4'd1;
            COIN_5C:  return 4'd5;
            COIN_10C: return 4'd10;
            default:  return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_change_gen.sv
// rtl/vend_change_gen.sv - greedy change picker: largest coin not exceeding the remaining credit
module vend_change_gen
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic [CREDIT_W-1:0] credit,
    output logic [1:0]          coin_code,
    output logic [CREDIT_W-1:0] coin_val
);

    // Pick 10c, then 5c, then 1c; zero credit yields no coin.
    always_comb begin
        coin_code = COIN_NONE;
        if (credit >= CREDIT_W'(10)) begin
            coin_code = COIN_10C;
        end else if (credit >= CREDIT_W'(5)) begin
            coin_code = COIN_5C;
        end else if (credit != '0) begin
            coin_code = COIN_1C;
        end
        coin_val = CREDIT_W'(coin_value(coin_code));
    end

endmodule

// File: rtl/multi_product_vending_ctrl.sv
// rtl/multi_product_vending_ctrl.sv - multi-product vending FSM with credit, stock bank and change payout
module multi_product_vending_ctrl
    import vend_pkg::*;
#(
    parameter int NUM_PRODUCTS = 4,
    parameter int CREDIT_W     = 8,
    parameter int MAX_CREDIT   = 200,
    parameter int STOCK_W      = 4,
    parameter int STOCK_INIT   = 8,
    parameter bit AUTO_CHANGE  = 1'b1,
    localparam int ID_W        = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [1:0]                       coin,
    input  logic                             sel_valid,
    input  logic [ID_W-1:0]                  sel_id,
    input  logic                             cancel,
    input  logic [NUM_PRODUCTS*CREDIT_W-1:0] price_table,
    input  logic                             restock,
    input  logic [ID_W-1:0]                  restock_id,
    output logic                             dispense,
    output logic [ID_W-1:0]                  dispense_id,
    output logic                             change_valid,
    output logic [1:0]                       change_coin,
    output logic [CREDIT_W-1:0]              credit,
    output logic                             coin_reject,
    output logic                             err_sold_out,
    output logic                             err_funds,
    output logic                             busy
);

    state_t              state;
    state_t              next_state;
    logic [ID_W-1:0]     id_q;
    logic [STOCK_W-1:0]  stock [NUM_PRODUCTS];
    logic [STOCK_W-1:0]  sel_stock;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W-1:0] price;
    logic [CREDIT_W-1:0] idle_credit;
    logic [CREDIT_W-1:0] chg_val;
    logic [1:0]          chg_code;
    logic [CREDIT_W:0]   credit_sum;
    logic                coin_ok;
    logic                id_ok;

    // One extra bit on the sum so the MAX_CREDIT guard sees overflow before it wraps.
    assign coin_val    = CREDIT_W'(coin_value(coin));
    assign credit_sum  = {1'b0, credit} + {1'b0, coin_val};
    assign coin_ok     = (credit_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    assign idle_credit = (coin != COIN_NONE && coin_ok) ? credit_sum[CREDIT_W-1:0] : credit;
    assign id_ok       = ({1'b0, id_q} < (ID_W+1)'(NUM_PRODUCTS));
    assign price       = id_ok ? price_table[int'(id_q)*CREDIT_W +: CREDIT_W] : '0;
    assign sel_stock   = id_ok ? stock[id_q] : '0;

    vend_change_gen #(
        .CREDIT_W (CREDIT_W)
    ) u_change_gen (
        .credit    (credit),
        .coin_code (chg_code),
        .coin_val  (chg_val)
    );

    // Next-state decode; a coin and a cancel in the same IDLE cycle refund the new credit.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (cancel) begin
                    if (idle_credit != '0) next_state = ST_CHANGE;
                end else if (sel_valid) begin
                    next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!id_ok || sel_stock == '0 || credit < price) next_state = ST_IDLE;
                else                                              next_state = ST_VEND;
            end
            ST_VEND: begin
                next_state = (AUTO_CHANGE && credit != price) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                if (credit == chg_val) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State, credit and all registered pulse outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            credit       <= '0;
            id_q         <= '0;
            dispense     <= 1'b0;
            dispense_id  <= '0;
            change_valid <= 1'b0;
            change_coin  <= COIN_NONE;
            coin_reject  <= 1'b0;
            err_sold_out <= 1'b0;
            err_funds    <= 1'b0;
        end else begin
            state        <= next_state;
            busy         <= (next_state != ST_IDLE);
            dispense     <= 1'b0;
            change_valid <= 1'b0;
            change_coin  <= COIN_NONE;
            err_sold_out <= 1'b0;
            err_funds    <= 1'b0;
            coin_reject  <= (coin != COIN_NONE) && (state != ST_IDLE || !coin_ok);
            case (state)
                ST_IDLE: begin
                    credit <= idle_credit;
                    if (!cancel && sel_valid) id_q <= sel_id;
                end
                ST_CHECK: begin
                    err_sold_out <= id_ok && sel_stock == '0;
                    err_funds    <= !id_ok || (sel_stock != '0 && credit < price);
                end
                ST_VEND: begin
                    dispense    <= 1'b1;
                    dispense_id <= id_q;
                    credit      <= credit - price;
                end
                ST_CHANGE: begin
                    change_valid <= 1'b1;
                    change_coin  <= chg_code;
                    credit       <= credit - chg_val;
                end
                default: ;
            endcase
        end
    end

    // Stock bank: restock reloads a slot and overrides a same-cycle vend decrement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PRODUCTS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
        end else begin
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                if (restock && restock_id == ID_W'(i)) begin
                    stock[i] <= STOCK_W'(STOCK_INIT);
                end else if (state == ST_VEND && id_q == ID_W'(i)) begin
                    stock[i] <= stock[i] - 1'b1;
                end
            end
        end
    end

endmodule
